// File: rtl/retire_unit_gen2.sv
// N-wide in-order commit stage: retires the oldest contiguous completed ROB head entries,
// ends a group at a mispredict (flush) or halt (sticky), and reports frees/arch writes a cycle later.
module retire_unit_gen2 #(
    parameter int N = 4,
    parameter int PHYS_REGS = 64,
    parameter int ARCH_REGS = 32,
    parameter int MAX_ST = 1,
    parameter int CNT_W = 32,
    localparam int PREG_W = $clog2(PHYS_REGS),
    localparam int AREG_W = $clog2(ARCH_REGS),
    localparam int NUM_W = $clog2(N + 1)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NUM_W-1:0]      rob_valid_cnt,
    input  logic [N*PREG_W-1:0]   rob_T_new,
    input  logic [N*PREG_W-1:0]   rob_T_old,
    input  logic [N*AREG_W-1:0]   rob_arch_reg,
    input  logic [N-1:0]          rob_is_store,
    input  logic [N-1:0]          rob_mispredict,
    input  logic [N-1:0]          rob_halt,
    input  logic [PHYS_REGS-1:0]  complete_list,
    input  logic [NUM_W-1:0]      sq_commit_room,
    output logic [NUM_W-1:0]      num_retiring,
    output logic [NUM_W-1:0]      stores_retiring,
    output logic [N-1:0]          free_valid,
    output logic [N*PREG_W-1:0]   free_preg,
    output logic [N-1:0]          arch_wr_en,
    output logic [N*AREG_W-1:0]   arch_wr_idx,
    output logic [N*PREG_W-1:0]   arch_wr_preg,
    output logic                  flush,
    output logic                  halted,
    output logic [CNT_W-1:0]      retired_count,
    output logic [1:0]            state_dbg
);

    // Handshake: there is no valid/ready pair here; the ROB pops exactly num_retiring
    // head entries at the clock edge that follows the cycle in which it is presented.

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_FLUSH  = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    localparam logic [NUM_W:0]   MAX_ST_W = (NUM_W + 1)'(MAX_ST);
    localparam logic [NUM_W-1:0] N_W      = NUM_W'(N);

    state_t state_q, state_d;

    logic [NUM_W-1:0]  eff_cnt;
    logic [NUM_W:0]    st_lim;
    logic [N-1:0]      retire_vec;
    logic              go;
    logic [NUM_W:0]    st_cnt;
    logic [NUM_W:0]    st_next;
    logic [NUM_W-1:0]  nr;
    logic [PREG_W-1:0] t_new_i;
    logic              mis_ret;
    logic              halt_ret;

    assign eff_cnt = (rob_valid_cnt > N_W) ? N_W : rob_valid_cnt;
    assign st_lim  = ({1'b0, sq_commit_room} > MAX_ST_W) ? MAX_ST_W : {1'b0, sq_commit_room};

    // Walk slots oldest first; the first blocked slot stops the whole group.
    always_comb begin
        retire_vec = '0;
        st_cnt     = '0;
        st_next    = '0;
        nr         = '0;
        t_new_i    = '0;
        go         = (state_q == S_RUN) && !reset;
        for (int i = 0; i < N; i++) begin
            t_new_i = rob_T_new[i*PREG_W +: PREG_W];
            st_next = st_cnt + (NUM_W + 1)'(rob_is_store[i]);
            if (go && (NUM_W'(i) < eff_cnt) && complete_list[t_new_i] && (st_next <= st_lim)) begin
                retire_vec[i] = 1'b1;
                st_cnt        = st_next;
                nr            = nr + NUM_W'(1);
                if (rob_mispredict[i] || rob_halt[i]) begin
                    go = 1'b0;
                end
            end else begin
                go = 1'b0;
            end
        end
    end

    assign num_retiring    = nr;
    assign stores_retiring = st_cnt[NUM_W-1:0];
    assign mis_ret         = |(retire_vec & rob_mispredict);
    assign halt_ret        = |(retire_vec & rob_halt);
    assign state_dbg       = state_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RUN: begin
                if (halt_ret) begin
                    state_d = S_HALTED;
                end else if (mis_ret) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH:  state_d = S_RUN;
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_RUN;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= S_RUN;
            flush         <= 1'b0;
            halted        <= 1'b0;
            retired_count <= '0;
            free_valid    <= '0;
            free_preg     <= '0;
            arch_wr_en    <= '0;
            arch_wr_idx   <= '0;
            arch_wr_preg  <= '0;
        end else begin
            state_q       <= state_d;
            flush         <= (state_d == S_FLUSH);
            halted        <= (state_d == S_HALTED);
            retired_count <= retired_count + CNT_W'(num_retiring);
            for (int i = 0; i < N; i++) begin
                if (retire_vec[i]) begin
                    free_valid[i]                    <= (rob_T_old[i*PREG_W +: PREG_W] != '0);
                    free_preg[i*PREG_W +: PREG_W]    <= rob_T_old[i*PREG_W +: PREG_W];
                    arch_wr_en[i]                    <= (rob_arch_reg[i*AREG_W +: AREG_W] != '0);
                    arch_wr_idx[i*AREG_W +: AREG_W]  <= rob_arch_reg[i*AREG_W +: AREG_W];
                    arch_wr_preg[i*PREG_W +: PREG_W] <= rob_T_new[i*PREG_W +: PREG_W];
                end else begin
                    free_valid[i]                    <= 1'b0;
                    free_preg[i*PREG_W +: PREG_W]    <= '0;
                    arch_wr_en[i]                    <= 1'b0;
                    arch_wr_idx[i*AREG_W +: AREG_W]  <= '0;
                    arch_wr_preg[i*PREG_W +: PREG_W] <= '0;
                end
            end
        end
    end

    a_nr_le_valid: assert property (@(posedge clock) disable iff (reset)
        num_retiring <= rob_valid_cnt);

    for (genvar g = 0; g < N; g++) begin : g_chk
        a_retire_complete: assert property (@(posedge clock) disable iff (reset)
            retire_vec[g] |-> complete_list[rob_T_new[g*PREG_W +: PREG_W]]);
        a_free_nonzero: assert property (@(posedge clock) disable iff (reset)
            free_valid[g] |-> (free_preg[g*PREG_W +: PREG_W] != '0));
    end

endmodule

// File: tb/tb_retire_unit_gen2.sv
// Directed bench for retire_unit_gen2: hand-derived retire counts per step, a small model for
// the registered outputs, and an expected queue compared one cycle after each step.
module tb_retire_unit_gen2;

    localparam int N = 4;
    localparam int PHYS_REGS = 64;
    localparam int ARCH_REGS = 32;
    localparam int MAX_ST = 1;
    localparam int CNT_W = 4;
    localparam int PREG_W = 6;
    localparam int AREG_W = 5;
    localparam int NUM_W = 3;
    localparam int EW = N + N*PREG_W + N + N*AREG_W + N*PREG_W + 2 + CNT_W;

    logic                 clock = 1'b0;
    logic                 reset;
    logic [NUM_W-1:0]     rob_valid_cnt;
    logic [N*PREG_W-1:0]  rob_T_new;
    logic [N*PREG_W-1:0]  rob_T_old;
    logic [N*AREG_W-1:0]  rob_arch_reg;
    logic [N-1:0]         rob_is_store;
    logic [N-1:0]         rob_mispredict;
    logic [N-1:0]         rob_halt;
    logic [PHYS_REGS-1:0] complete_list;
    logic [NUM_W-1:0]     sq_commit_room;
    logic [NUM_W-1:0]     num_retiring;
    logic [NUM_W-1:0]     stores_retiring;
    logic [N-1:0]         free_valid;
    logic [N*PREG_W-1:0]  free_preg;
    logic [N-1:0]         arch_wr_en;
    logic [N*AREG_W-1:0]  arch_wr_idx;
    logic [N*PREG_W-1:0]  arch_wr_preg;
    logic                 flush;
    logic                 halted;
    logic [CNT_W-1:0]     retired_count;
    logic [1:0]           state_dbg;

    always #5 clock = ~clock;

    retire_unit_gen2 #(
        .N(N), .PHYS_REGS(PHYS_REGS), .ARCH_REGS(ARCH_REGS), .MAX_ST(MAX_ST), .CNT_W(CNT_W)
    ) dut (
        .clock(clock), .reset(reset),
        .rob_valid_cnt(rob_valid_cnt), .rob_T_new(rob_T_new), .rob_T_old(rob_T_old),
        .rob_arch_reg(rob_arch_reg), .rob_is_store(rob_is_store),
        .rob_mispredict(rob_mispredict), .rob_halt(rob_halt),
        .complete_list(complete_list), .sq_commit_room(sq_commit_room),
        .num_retiring(num_retiring), .stores_retiring(stores_retiring),
        .free_valid(free_valid), .free_preg(free_preg),
        .arch_wr_en(arch_wr_en), .arch_wr_idx(arch_wr_idx), .arch_wr_preg(arch_wr_preg),
        .flush(flush), .halted(halted), .retired_count(retired_count), .state_dbg(state_dbg)
    );

    int n_cmp = 0;
    int n_fail = 0;
    logic [EW-1:0] exp_q[$];
    logic [CNT_W-1:0] m_count = '0;
    logic m_halted = 1'b0;

    task automatic check(input string tag, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        n_cmp++;
        assert (act === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [EW-1:0] reg_snapshot();
        return {free_valid, free_preg, arch_wr_en, arch_wr_idx, arch_wr_preg,
                flush, halted, retired_count};
    endfunction

    // Slot i: T_new=10+i, T_old=20+i, arch=1+i, plain ALU op, everything complete.
    task automatic base_rob(input int cnt);
        rob_valid_cnt  = NUM_W'(cnt);
        rob_is_store   = '0;
        rob_mispredict = '0;
        rob_halt       = '0;
        complete_list  = '1;
        sq_commit_room = 3'd2;
        for (int i = 0; i < N; i++) begin
            rob_T_new[i*PREG_W +: PREG_W]    = PREG_W'(10 + i);
            rob_T_old[i*PREG_W +: PREG_W]    = PREG_W'(20 + i);
            rob_arch_reg[i*AREG_W +: AREG_W] = AREG_W'(1 + i);
        end
    endtask

    task automatic reset_check(input string tag);
        check({tag, " regs"}, reg_snapshot(), '0);
        check({tag, " nr"}, EW'(num_retiring), '0);
        check({tag, " sr"}, EW'(stores_retiring), '0);
        m_count  = '0;
        m_halted = 1'b0;
    endtask

    // Inputs are already driven; check comb counts, predict next-edge outputs, then compare.
    task automatic step(input string tag, input int exp_nr, input int exp_sr);
        logic [N-1:0]        fv, we;
        logic [N*PREG_W-1:0] fp, wp;
        logic [N*AREG_W-1:0] wi;
        logic                fl, hr;
        #1;
        check({tag, " nr"}, EW'(num_retiring), EW'(exp_nr));
        check({tag, " sr"}, EW'(stores_retiring), EW'(exp_sr));
        fv = '0; we = '0; fp = '0; wp = '0; wi = '0;
        for (int i = 0; i < exp_nr; i++) begin
            fv[i]                  = (rob_T_old[i*PREG_W +: PREG_W] != 0);
            fp[i*PREG_W +: PREG_W] = rob_T_old[i*PREG_W +: PREG_W];
            we[i]                  = (rob_arch_reg[i*AREG_W +: AREG_W] != 0);
            wi[i*AREG_W +: AREG_W] = rob_arch_reg[i*AREG_W +: AREG_W];
            wp[i*PREG_W +: PREG_W] = rob_T_new[i*PREG_W +: PREG_W];
        end
        fl = 1'b0;
        hr = 1'b0;
        if (exp_nr > 0) begin
            hr = rob_halt[exp_nr-1];
            fl = rob_mispredict[exp_nr-1] && !hr;
        end
        m_halted = m_halted | hr;
        m_count  = m_count + CNT_W'(exp_nr);
        exp_q.push_back({fv, fp, we, wi, wp, fl, m_halted, m_count});
        @(posedge clock);
        #1;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $error("FAIL %s: scoreboard empty", tag);
        end else begin
            check({tag, " regs"}, reg_snapshot(), exp_q.pop_front());
        end
    endtask

    initial begin
        reset = 1'b1;
        base_rob(4);
        #12;
        reset_check("reset");
        reset = 1'b0;

        base_rob(4);
        step("all4", 4, 0);

        base_rob(4);
        complete_list[11] = 1'b0;
        step("slot1_incomplete", 1, 0);

        base_rob(4);
        rob_is_store[1:0] = 2'b11;
        step("two_stores_room2", 1, 1);

        base_rob(4);
        rob_is_store[0] = 1'b1;
        sq_commit_room = 3'd0;
        step("store_no_room", 0, 0);

        base_rob(0);
        step("empty_rob", 0, 0);

        base_rob(7);
        rob_T_old[2*PREG_W +: PREG_W]    = '0;
        rob_arch_reg[3*AREG_W +: AREG_W] = '0;
        rob_arch_reg[1*AREG_W +: AREG_W] = 5'd1;
        rob_is_store[3] = 1'b1;
        sq_commit_room = 3'd1;
        step("cnt_over_n_mixed", 4, 1);

        base_rob(4);
        rob_mispredict[1] = 1'b1;
        step("mispredict_slot1", 2, 0);

        base_rob(4);
        step("flush_bubble", 0, 0);

        base_rob(2);
        step("after_flush", 2, 0);

        base_rob(3);
        step("count_wrap", 3, 0);

        base_rob(4);
        rob_halt[2] = 1'b1;
        rob_mispredict[2] = 1'b1;
        step("halt_slot2", 3, 0);

        base_rob(4);
        step("halted_idle1", 0, 0);
        base_rob(1);
        step("halted_idle2", 0, 0);

        reset = 1'b1;
        #1;
        reset_check("reset_from_halt");
        #2;
        reset = 1'b0;

        base_rob(4);
        rob_halt[0] = 1'b1;
        step("halt_slot0", 1, 0);
        reset = 1'b1;
        #1;
        reset_check("reset_after_halt0");
        #2;
        reset = 1'b0;

        base_rob(4);
        step("post_reset", 4, 0);

        base_rob(4);
        #1;
        check("mid_nr", EW'(num_retiring), EW'(4));
        reset = 1'b1;
        #1;
        reset_check("mid_retire_reset");
        #2;
        reset = 1'b0;

        base_rob(4);
        step("resume", 4, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
